// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port between the instruction cache (port 0)
// and the data cache (port 1); the grant is held until the owner's read bursts have fully returned.
module mem_arbiter #(
    parameter int DATABITS  = 32,
    parameter int ADDRBITS  = 32,
    parameter int BURSTBITS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDRBITS-1:0]  p0_addr,
    input  logic [DATABITS-1:0]  p0_in,
    input  logic                 p0_rdreq,
    input  logic                 p0_wrreq,
    output logic                 p0_grant,
    output logic [DATABITS-1:0]  p0_out,
    output logic                 p0_out_valid,
    output logic [BURSTBITS-1:0] p0_burstlen,
    input  logic [ADDRBITS-1:0]  p1_addr,
    input  logic [DATABITS-1:0]  p1_in,
    input  logic                 p1_rdreq,
    input  logic                 p1_wrreq,
    output logic                 p1_grant,
    output logic [DATABITS-1:0]  p1_out,
    output logic                 p1_out_valid,
    output logic [BURSTBITS-1:0] p1_burstlen,
    output logic [ADDRBITS-1:0]  mem_addr,
    output logic [DATABITS-1:0]  mem_in,
    output logic                 mem_rdreq,
    output logic                 mem_wrreq,
    input  logic [DATABITS-1:0]  mem_out,
    input  logic                 mem_out_valid,
    input  logic [BURSTBITS-1:0] mem_burstlen
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic                 owner;
    logic                 last_grant;
    logic [BURSTBITS-1:0] cnt;

    logic                 pend0;
    logic                 pend1;
    logic                 sel;
    logic                 sel_valid;
    logic                 port;
    logic                 port_rd;
    logic                 port_wr;
    logic [ADDRBITS-1:0]  port_addr;
    logic [DATABITS-1:0]  port_in;
    logic [BURSTBITS-1:0] cnt_next;
    logic                 release_now;

    // In IDLE the arbitration winner is the port of interest; in BUSY it is the current owner.
    always_comb begin
        pend0     = p0_rdreq | p0_wrreq;
        pend1     = p1_rdreq | p1_wrreq;
        sel       = (pend0 && pend1) ? ~last_grant : pend1;
        sel_valid = pend0 | pend1;
        port      = (state == BUSY) ? owner : sel;
        port_rd   = port ? p1_rdreq : p0_rdreq;
        port_wr   = port ? p1_wrreq : p0_wrreq;
        port_addr = port ? p1_addr  : p0_addr;
        port_in   = port ? p1_in    : p0_in;

        if (port_rd && cnt == '0)
            cnt_next = mem_burstlen;
        else if (mem_out_valid && cnt != '0)
            cnt_next = cnt - BURSTBITS'(1);
        else
            cnt_next = cnt;

        release_now = (state == BUSY) && !port_rd && !port_wr && (cnt_next == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            p0_grant   <= 1'b0;
            p1_grant   <= 1'b0;
            mem_addr   <= '0;
            mem_in     <= '0;
            mem_rdreq  <= 1'b0;
            mem_wrreq  <= 1'b0;
        end else begin
            cnt <= cnt_next;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state      <= BUSY;
                        owner      <= sel;
                        last_grant <= sel;
                        p0_grant   <= ~sel;
                        p1_grant   <= sel;
                        mem_addr   <= port_addr;
                        mem_in     <= port_in;
                        mem_rdreq  <= port_rd;
                        mem_wrreq  <= port_wr;
                    end else begin
                        mem_rdreq <= 1'b0;
                        mem_wrreq <= 1'b0;
                    end
                end
                BUSY: begin
                    mem_addr <= port_addr;
                    mem_in   <= port_in;
                    // Releasing never grants in the same edge; the next IDLE cycle arbitrates.
                    if (release_now) begin
                        state     <= IDLE;
                        p0_grant  <= 1'b0;
                        p1_grant  <= 1'b0;
                        mem_rdreq <= 1'b0;
                        mem_wrreq <= 1'b0;
                    end else begin
                        mem_rdreq <= port_rd;
                        mem_wrreq <= port_wr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign p0_out       = mem_out;
    assign p1_out       = mem_out;
    assign p0_burstlen  = mem_burstlen;
    assign p1_burstlen  = mem_burstlen;
    assign p0_out_valid = mem_out_valid & p0_grant;
    assign p1_out_valid = mem_out_valid & p1_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand-built corner sequences and a randomized run
// against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int DATABITS  = 32;
    localparam int ADDRBITS  = 32;
    localparam int BURSTBITS = 16;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [ADDRBITS-1:0]  p0_addr, p1_addr;
    logic [DATABITS-1:0]  p0_in, p1_in;
    logic                 p0_rdreq, p0_wrreq, p1_rdreq, p1_wrreq;
    logic                 p0_grant, p1_grant;
    logic [DATABITS-1:0]  p0_out, p1_out;
    logic                 p0_out_valid, p1_out_valid;
    logic [BURSTBITS-1:0] p0_burstlen, p1_burstlen;
    logic [ADDRBITS-1:0]  mem_addr;
    logic [DATABITS-1:0]  mem_in;
    logic                 mem_rdreq, mem_wrreq;
    logic [DATABITS-1:0]  mem_out;
    logic                 mem_out_valid;
    logic [BURSTBITS-1:0] mem_burstlen;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.DATABITS(DATABITS), .ADDRBITS(ADDRBITS), .BURSTBITS(BURSTBITS)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_addr(p0_addr), .p0_in(p0_in), .p0_rdreq(p0_rdreq), .p0_wrreq(p0_wrreq),
        .p0_grant(p0_grant), .p0_out(p0_out), .p0_out_valid(p0_out_valid), .p0_burstlen(p0_burstlen),
        .p1_addr(p1_addr), .p1_in(p1_in), .p1_rdreq(p1_rdreq), .p1_wrreq(p1_wrreq),
        .p1_grant(p1_grant), .p1_out(p1_out), .p1_out_valid(p1_out_valid), .p1_burstlen(p1_burstlen),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq),
        .mem_out(mem_out), .mem_out_valid(mem_out_valid), .mem_burstlen(mem_burstlen)
    );

    always #5 clk = ~clk;

    // ov0/ov1 are expected during the cycle; g0/g1/mrd/mwr just after the following edge.
    typedef struct {
        logic        p0_rd, p0_wr, p1_rd, p1_wr, valid;
        logic [15:0] bl;
        logic        ov0, ov1, g0, g1, mrd, mwr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic p0_rd, input logic p0_wr, input logic p1_rd,
                                input logic p1_wr, input logic valid, input logic [15:0] bl,
                                input logic ov0, input logic ov1, input logic g0, input logic g1,
                                input logic mrd, input logic mwr);
        vec_t v;
        v.p0_rd = p0_rd; v.p0_wr = p0_wr; v.p1_rd = p1_rd; v.p1_wr = p1_wr;
        v.valid = valid; v.bl = bl;
        v.ov0 = ov0; v.ov1 = ov1; v.g0 = g0; v.g1 = g1; v.mrd = mrd; v.mwr = mwr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    task automatic idleInputs();
        p0_addr = '0; p0_in = '0; p0_rdreq = 1'b0; p0_wrreq = 1'b0;
        p1_addr = '0; p1_in = '0; p1_rdreq = 1'b0; p1_wrreq = 1'b0;
        mem_out = '0; mem_out_valid = 1'b0; mem_burstlen = '0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_p0_grant"}, p0_grant, 0);
        checkOutput({tag, "_p1_grant"}, p1_grant, 0);
        checkOutput({tag, "_mem_rdreq"}, mem_rdreq, 0);
        checkOutput({tag, "_mem_wrreq"}, mem_wrreq, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_in"}, mem_in, 0);
    endtask

    task automatic doReset();
        idleInputs();
        reset_n = 1'b0;
        @(posedge clk); #1;
        checkResetValues("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        p0_rdreq = v.p0_rd; p0_wrreq = v.p0_wr;
        p1_rdreq = v.p1_rd; p1_wrreq = v.p1_wr;
        mem_out_valid = v.valid; mem_burstlen = v.bl;
        mem_out = 32'hD000_0000 + 32'(idx);
        #2;
        checkOutput($sformatf("vec%0d_p0_out_valid", idx), p0_out_valid, v.ov0);
        checkOutput($sformatf("vec%0d_p1_out_valid", idx), p1_out_valid, v.ov1);
        if (v.valid)
            checkOutput($sformatf("vec%0d_p1_out", idx), p1_out, 32'hD000_0000 + 32'(idx));
        @(posedge clk); #1;
        checkOutput($sformatf("vec%0d_p0_grant", idx), p0_grant, v.g0);
        checkOutput($sformatf("vec%0d_p1_grant", idx), p1_grant, v.g1);
        checkOutput($sformatf("vec%0d_mem_rdreq", idx), mem_rdreq, v.mrd);
        checkOutput($sformatf("vec%0d_mem_wrreq", idx), mem_wrreq, v.mwr);
    endtask

    // Transaction-level model: who owns the port, who owned it last, and how many beats remain.
    task automatic runRandom(input int cycles);
        int           owner, last, outst, pick;
        logic         rd[2], wr[2];
        logic [31:0]  addr[2], din[2];
        logic         valid;
        logic [15:0]  bl;
        logic [31:0]  exp_addr, exp_in;
        logic         exp_rd, exp_wr;
        owner = -1; last = 1; outst = 0;
        exp_addr = '0; exp_in = '0; exp_rd = 1'b0; exp_wr = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            for (int k = 0; k < 2; k++) begin
                rd[k]   = ($urandom_range(3) == 0);
                wr[k]   = ($urandom_range(2) == 0);
                addr[k] = $urandom;
                din[k]  = $urandom;
            end
            valid = 1'($urandom_range(1));
            bl    = 16'($urandom_range(5));
            p0_rdreq = rd[0]; p0_wrreq = wr[0]; p0_addr = addr[0]; p0_in = din[0];
            p1_rdreq = rd[1]; p1_wrreq = wr[1]; p1_addr = addr[1]; p1_in = din[1];
            mem_out_valid = valid; mem_burstlen = bl; mem_out = $urandom;
            #2;
            checkOutput("rand_p0_out_valid", p0_out_valid, valid && owner == 0);
            checkOutput("rand_p1_out_valid", p1_out_valid, valid && owner == 1);
            if (owner < 0) begin
                pick = -1;
                if ((rd[0] || wr[0]) && (rd[1] || wr[1])) pick = 1 - last;
                else if (rd[0] || wr[0]) pick = 0;
                else if (rd[1] || wr[1]) pick = 1;
                if (pick >= 0) begin
                    owner = pick; last = pick;
                    exp_addr = addr[pick]; exp_in = din[pick];
                    exp_rd = rd[pick]; exp_wr = wr[pick];
                    if (rd[pick] && outst == 0) outst = int'(bl);
                end else begin
                    exp_rd = 1'b0; exp_wr = 1'b0;
                end
            end else begin
                exp_addr = addr[owner]; exp_in = din[owner];
                if (rd[owner] && outst == 0) outst = int'(bl);
                else if (valid && outst > 0) outst--;
                if (!rd[owner] && !wr[owner] && outst == 0) begin
                    owner = -1; exp_rd = 1'b0; exp_wr = 1'b0;
                end else begin
                    exp_rd = rd[owner]; exp_wr = wr[owner];
                end
            end
            @(posedge clk); #1;
            checkOutput("rand_p0_grant", p0_grant, owner == 0);
            checkOutput("rand_p1_grant", p1_grant, owner == 1);
            checkOutput("rand_mem_rdreq", mem_rdreq, exp_rd);
            checkOutput("rand_mem_wrreq", mem_wrreq, exp_wr);
            checkOutput("rand_mem_addr", mem_addr, exp_addr);
            checkOutput("rand_mem_in", mem_in, exp_in);
        end
    endtask

    initial begin
        int          cycles;
        logic [31:0] burst_data[8];
        logic [31:0] a0, a1;
        logic        prev0, prev1;
        int          order[$];

        doReset();

        // Single read on port 1, strays in IDLE, an ownership with stray valid, zero-length read, tie.
        vecs.push_back(mk(0,0,1,0, 0,16'd4, 0,0, 0,1,1,0));
        vecs.push_back(mk(0,0,0,0, 0,16'd4, 0,0, 0,1,0,0));
        vecs.push_back(mk(0,0,0,0, 0,16'd4, 0,0, 0,1,0,0));
        vecs.push_back(mk(0,0,0,0, 1,16'd4, 0,1, 0,1,0,0));
        vecs.push_back(mk(0,0,0,0, 1,16'd4, 0,1, 0,1,0,0));
        vecs.push_back(mk(0,0,0,0, 1,16'd4, 0,1, 0,1,0,0));
        vecs.push_back(mk(0,0,0,0, 1,16'd4, 0,1, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,16'd4, 0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'd4, 0,0, 1,0,0,1));
        vecs.push_back(mk(0,0,0,0, 1,16'd4, 1,0, 0,0,0,0));
        vecs.push_back(mk(0,0,1,0, 0,16'd0, 0,0, 0,1,1,0));
        vecs.push_back(mk(0,0,0,0, 0,16'd0, 0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,1, 0,16'd2, 0,0, 1,0,1,0));
        vecs.push_back(mk(0,0,0,1, 1,16'd2, 1,0, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1, 1,16'd2, 1,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,1, 0,16'd2, 0,0, 0,1,0,1));
        vecs.push_back(mk(0,0,0,0, 0,16'd2, 0,0, 0,0,0,0));
        foreach (vecs[i]) applyStimulus(i, vecs[i]);

        // Tie straight after reset: port 0 first, port 1 two cycles after port 0 lets go.
        doReset();
        p0_addr = 32'h1000; p0_in = 32'hAAAA_0000; p0_wrreq = 1'b1;
        p1_addr = 32'h2000; p1_in = 32'hBBBB_0000; p1_wrreq = 1'b1;
        @(posedge clk); #1;
        checkOutput("tie_first_p0_grant", p0_grant, 1);
        checkOutput("tie_first_p1_grant", p1_grant, 0);
        checkOutput("tie_first_mem_addr", mem_addr, 32'h1000);
        repeat (2) @(posedge clk);
        #1;
        p0_wrreq = 1'b0;
        cycles = 0;
        while (!p1_grant && cycles < 10) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("tie_switch_delay", cycles, 2);
        checkOutput("tie_second_mem_addr", mem_addr, 32'h2000);
        checkOutput("tie_second_mem_wrreq", mem_wrreq, 1);
        p1_wrreq = 1'b0;
        @(posedge clk); #1;
        checkOutput("tie_second_release", p1_grant, 0);

        // Eight-beat write burst on port 0 while port 1 waits.
        p1_addr = 32'h3000; p1_in = 32'hCCCC_0000; p1_wrreq = 1'b1;
        for (int k = 0; k < 8; k++) begin
            burst_data[k] = $urandom;
            p0_wrreq = 1'b1; p0_addr = 32'h100 + 32'(4 * k); p0_in = burst_data[k];
            @(posedge clk); #1;
            checkOutput($sformatf("burst%0d_mem_wrreq", k), mem_wrreq, 1);
            checkOutput($sformatf("burst%0d_mem_addr", k), mem_addr, 32'h100 + 32'(4 * k));
            checkOutput($sformatf("burst%0d_mem_in", k), mem_in, burst_data[k]);
            checkOutput($sformatf("burst%0d_p0_grant", k), p0_grant, 1);
            checkOutput($sformatf("burst%0d_p1_grant", k), p1_grant, 0);
        end
        p0_wrreq = 1'b0;
        @(posedge clk); #1;
        checkOutput("burst_release_p0_grant", p0_grant, 0);
        checkOutput("burst_release_mem_wrreq", mem_wrreq, 0);
        checkOutput("burst_release_p1_grant", p1_grant, 0);
        @(posedge clk); #1;
        checkOutput("burst_after_p1_grant", p1_grant, 1);
        checkOutput("burst_after_mem_addr", mem_addr, 32'h3000);
        p1_wrreq = 1'b0;
        @(posedge clk); #1;

        // Both ports issuing single-beat writes back to back.
        prev0 = 1'b0; prev1 = 1'b0;
        for (int c = 0; c < 32; c++) begin
            p0_wrreq = !p0_grant; p1_wrreq = !p1_grant;
            a0 = $urandom; a1 = $urandom;
            p0_addr = a0; p1_addr = a1;
            @(posedge clk); #1;
            checkOutput("rr_not_both_granted", p0_grant & p1_grant, 0);
            if (p0_grant && !prev0) begin
                order.push_back(0);
                checkOutput("rr_mem_addr_p0", mem_addr, a0);
            end
            if (p1_grant && !prev1) begin
                order.push_back(1);
                checkOutput("rr_mem_addr_p1", mem_addr, a1);
            end
            prev0 = p0_grant; prev1 = p1_grant;
        end
        checkOutput("rr_grant_count", order.size(), 16);
        foreach (order[i]) checkOutput($sformatf("rr_order%0d", i), order[i], i % 2);
        idleInputs();
        @(posedge clk); #1;

        // Reset asserted after two of four read beats, then a clean burst.
        p0_rdreq = 1'b1; p0_addr = 32'h4000; p0_in = 32'h4444_4444; mem_burstlen = 16'd4;
        @(posedge clk); #1;
        checkOutput("rst_burst_p0_grant", p0_grant, 1);
        checkOutput("rst_burst_mem_rdreq", mem_rdreq, 1);
        p0_rdreq = 1'b0;
        repeat (2) begin
            mem_out_valid = 1'b1;
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        checkResetValues("midburst");
        checkOutput("midburst_p0_out_valid", p0_out_valid, 0);
        mem_out_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        p0_rdreq = 1'b1; mem_burstlen = 16'd4;
        @(posedge clk); #1;
        checkOutput("post_reset_p0_grant", p0_grant, 1);
        p0_rdreq = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_out_valid = 1'b1;
            #2;
            checkOutput($sformatf("post_reset_beat%0d_valid", b), p0_out_valid, 1);
            @(posedge clk); #1;
            checkOutput($sformatf("post_reset_beat%0d_grant", b), p0_grant, b < 3);
        end
        mem_out_valid = 1'b0;

        doReset();
        runRandom(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single memory-controller port (mem_addr/mem_in/mem_out/mem_out_valid/mem_rdreq/mem_wrreq/mem_burstlen) between the instruction cache (port 0) and the data cache (port 1). It grants the controller to one requester at a time using round-robin arbitration. It holds the grant until the requester's read bursts have fully returned and its request lines are low. Requester-to-controller signals are registered; the return path is combinational.

## Interface
- DATABITS, 32, data word width
- ADDRBITS, 32, address width
- BURSTBITS, 16, width of burst length and outstanding-beat counter
- clk  input  1  system clock, rising edge
- reset_n  input  1  reset, asynchronous, active-low
- p0_addr / p1_addr  input  ADDRBITS  requester address
- p0_in / p1_in  input  DATABITS  requester write data
- p0_rdreq / p1_rdreq  input  1  read-burst request, level
- p0_wrreq / p1_wrreq  input  1  write beat request, one word per cycle
- p0_grant / p1_grant  output  1  registered; the port owns the controller
- p0_out / p1_out  output  DATABITS  both driven with mem_out
- p0_out_valid / p1_out_valid  output  1  mem_out_valid gated by that port's grant
- p0_burstlen / p1_burstlen  output  BURSTBITS  both driven with mem_burstlen
- mem_addr  output  ADDRBITS  registered address to controller
- mem_in  output  DATABITS  registered write data
- mem_rdreq / mem_wrreq  output  1  registered requests
- mem_out  input  DATABITS  read data
- mem_out_valid  input  1  read beat valid
- mem_burstlen  input  BURSTBITS  words per read burst

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant=g, where g∈{0,1}.
  - last_grant register records the previous owner.
- IDLE:
  - pend0 = p0_rdreq|p0_wrreq; pend1 likewise.
  - If exactly one is pending, select that port. If both are pending, select !last_grant.
  - On selection: state←BUSY, g←sel, pN_grant←1, last_grant←sel. Forward the selected port's addr/in/rdreq/wrreq to mem_* on this edge.
  - Nothing pending: mem_rdreq=mem_wrreq=0; mem_addr and mem_in hold their values.
- BUSY: every edge, mem_addr/mem_in/mem_rdreq/mem_wrreq ← port g's inputs. The non-granted port's inputs are ignored and not captured.
- Handshake: a requester holds rdreq/wrreq until its grant is high. Beats presented before grant are not forwarded.
- Outstanding counter cnt (BURSTBITS, reset 0):
  - Port g rdreq=1 and cnt==0: cnt←mem_burstlen.
  - Else if mem_out_valid and cnt>0: cnt←cnt-1.
  - Any mem_out_valid with cnt==0 is ignored and never underflows.
- Release: in BUSY, when port g has rdreq=0, wrreq=0, and next-cnt==0:
  - state←IDLE, pN_grant←0, mem_rdreq←0, mem_wrreq←0.
  - The release edge cannot also issue a new grant; arbitration resumes in the following IDLE cycle.
- mem_burstlen=0 on a read: cnt stays 0, so release occurs once rdreq drops.
- Return path: pN_out_valid = mem_out_valid & pN_grant. It is never asserted on both ports, and both are 0 in IDLE.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (so port 0 wins the first tie), cnt=0.
  - p0_grant=p1_grant=0, mem_rdreq=mem_wrreq=0, mem_addr=0, mem_in=0.
  - Asserting reset_n low mid-burst aborts immediately; in-flight beats are dropped.
- Request to mem_*: 1 cycle. A request at cycle T appears on mem_* and on grant at T+1.
- Write beats: beat k at requester cycle T+k appears at the controller at T+k+1. No beats are lost or duplicated while granted.
- Minimum ownership: 1 cycle, then 1 idle cycle before any new grant. A back-to-back switch costs 2 cycles.
- Read data: 0-cycle combinational path from mem_out/mem_out_valid to the granted port.

## Test plan
- Single read, port 1, burstlen=4:
  - Stimulus: p1_rdreq for 1 cycle at T; controller returns 4 valids at T+3..T+6.
  - Response: p1_grant high at T+1 through T+6; mem_rdreq high only at T+1; p1_out_valid pulses 4×; p0_out_valid stays 0; IDLE at T+7.
- Tie:
  - Stimulus: p0 and p1 both raise wrreq at T after reset.
  - Response: port 0 granted first. After p0 drops wrreq, port 1 is granted exactly 2 cycles later.
- Round-robin:
  - Stimulus: both ports continuously request 1-beat writes.
  - Response: grants alternate 0,1,0,1. Each mem_addr matches the granted port's p_addr.
- Write burst, port 0, 8 beats at addr 0x100..0x11C:
  - Response: mem_wrreq high for 8 consecutive cycles with identical addr/data, delayed 1 cycle; port 1 held off throughout.
- Stray mem_out_valid:
  - Stimulus: mem_out_valid in IDLE, and extra valids after cnt reaches 0.
  - Response: no pN_out_valid; cnt stays 0.
- Reset mid-burst:
  - Stimulus: reset_n low after 2 of 4 read beats.
  - Response: all outputs reach reset values asynchronously. After release, a new p0 read is granted normally and a full burst completes.
